// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin encodings, coin values and the
// credit-handling state set used by the coin accumulator and change logic.
package vm_pkg;

    localparam int AMT_W_DEF = 5;

    localparam logic [1:0] COIN_1  = 2'b00;
    localparam logic [1:0] COIN_2  = 2'b01;
    localparam logic [1:0] COIN_5  = 2'b10;
    localparam logic [1:0] COIN_10 = 2'b11;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_REFUND  = 1'b1
    } state_t;

    function automatic logic [3:0] coin_value(input logic [1:0] i_type);
        case (i_type)
            COIN_1:  return 4'd1;
            COIN_2:  return 4'd2;
            COIN_5:  return 4'd5;
            default: return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/change_picker.sv
// Largest-fit change denomination for a given amount (10, 5, 2, then 1).
// Purely combinational so any change dispenser can reuse it.
module change_picker
    import vm_pkg::*;
#(
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic [AMT_W-1:0] i_amount,
    output logic [1:0]       o_change_type,
    output logic [3:0]       o_value
);

    always_comb begin
        o_change_type = COIN_1;
        if (i_amount >= AMT_W'(10)) begin
            o_change_type = COIN_10;
        end else if (i_amount >= AMT_W'(5)) begin
            o_change_type = COIN_5;
        end else if (i_amount >= AMT_W'(2)) begin
            o_change_type = COIN_2;
        end
        o_value = coin_value(o_change_type);
    end

endmodule

// File: rtl/coin_accumulator.sv
// Coin credit accumulator: collects coins up to a ceiling, charges on vend and
// returns change one coin at a time on cancel or after a vend leaves a remainder.
module coin_accumulator
    import vm_pkg::*;
#(
    parameter int AMT_W      = AMT_W_DEF,
    parameter int MAX_AMOUNT = 31,
    parameter int CHANGE_GAP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin_valid,
    input  logic [1:0]       coin_type,
    input  logic             cancel,
    input  logic             vend,
    input  logic [AMT_W-1:0] product_price,
    output logic [AMT_W-1:0] current_amount,
    output logic             coin_accept,
    output logic             coin_reject,
    output logic             change_valid,
    output logic [1:0]       change_type,
    output logic             busy
);

    localparam int GAP_W = (CHANGE_GAP > 1) ? $clog2(CHANGE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(CHANGE_GAP - 1);

    state_t           r_state;
    logic [AMT_W-1:0] r_amount;
    logic [GAP_W-1:0] r_gap;
    logic             r_coin_accept;
    logic             r_coin_reject;
    logic             r_change_valid;
    logic [1:0]       r_change_type;
    logic [3:0]       r_change_val;

    state_t           w_state_nxt;
    logic [AMT_W-1:0] w_amount_nxt;
    logic [GAP_W-1:0] w_gap_nxt;
    logic             w_accept_nxt;
    logic             w_reject_nxt;
    logic             w_cv_nxt;
    logic [1:0]       w_ct_nxt;
    logic [3:0]       w_cval_nxt;
    logic             w_taken;

    logic             w_vend_ok;
    logic [AMT_W-1:0] w_rem;
    logic [AMT_W-1:0] w_amt_after;
    logic [AMT_W:0]   w_sum;
    logic [AMT_W-1:0] w_pick_amt;
    logic [1:0]       w_pick_type;
    logic [3:0]       w_pick_val;

    assign w_vend_ok   = vend && (r_amount >= product_price);
    assign w_rem       = r_amount - product_price;
    // The coin on the output this cycle leaves the register at the coming edge.
    assign w_amt_after = r_amount - (r_change_valid ? AMT_W'(r_change_val) : '0);
    assign w_sum       = {1'b0, r_amount} + (AMT_W + 1)'(coin_value(coin_type));
    assign w_pick_amt  = (r_state == ST_REFUND) ? w_amt_after :
                         (w_vend_ok ? w_rem : r_amount);

    change_picker #(
        .AMT_W(AMT_W)
    ) u_change_picker (
        .i_amount      (w_pick_amt),
        .o_change_type (w_pick_type),
        .o_value       (w_pick_val)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_amount_nxt = r_amount;
        w_gap_nxt    = r_gap;
        w_accept_nxt = 1'b0;
        w_reject_nxt = 1'b0;
        w_cv_nxt     = 1'b0;
        w_ct_nxt     = r_change_type;
        w_cval_nxt   = r_change_val;
        w_taken      = 1'b0;

        case (r_state)
            ST_COLLECT: begin
                if (w_vend_ok) begin
                    w_taken = 1'b1;
                    if (w_rem == '0) begin
                        w_amount_nxt = '0;
                    end else begin
                        w_state_nxt  = ST_REFUND;
                        w_amount_nxt = w_rem;
                        w_cv_nxt     = 1'b1;
                        w_ct_nxt     = w_pick_type;
                        w_cval_nxt   = w_pick_val;
                        w_gap_nxt    = GAP_RELOAD;
                    end
                end else if (cancel && (r_amount != '0)) begin
                    w_taken     = 1'b1;
                    w_state_nxt = ST_REFUND;
                    w_cv_nxt    = 1'b1;
                    w_ct_nxt    = w_pick_type;
                    w_cval_nxt  = w_pick_val;
                    w_gap_nxt   = GAP_RELOAD;
                end

                if (coin_valid) begin
                    if (!w_taken && (w_sum <= (AMT_W + 1)'(MAX_AMOUNT))) begin
                        w_accept_nxt = 1'b1;
                        w_amount_nxt = w_sum[AMT_W-1:0];
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end
            end

            ST_REFUND: begin
                w_reject_nxt = coin_valid;
                if (r_amount == '0) begin
                    w_state_nxt = ST_COLLECT;
                    w_gap_nxt   = '0;
                end else begin
                    w_amount_nxt = w_amt_after;
                    if ((r_gap == '0) && (w_amt_after != '0)) begin
                        w_cv_nxt   = 1'b1;
                        w_ct_nxt   = w_pick_type;
                        w_cval_nxt = w_pick_val;
                        w_gap_nxt  = GAP_RELOAD;
                    end else if (r_gap != '0) begin
                        w_gap_nxt = r_gap - 1'b1;
                    end
                end
            end

            default: w_state_nxt = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_COLLECT;
            r_amount       <= '0;
            r_gap          <= '0;
            r_coin_accept  <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_change_valid <= 1'b0;
            r_change_type  <= COIN_1;
            r_change_val   <= 4'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_amount       <= w_amount_nxt;
            r_gap          <= w_gap_nxt;
            r_coin_accept  <= w_accept_nxt;
            r_coin_reject  <= w_reject_nxt;
            r_change_valid <= w_cv_nxt;
            r_change_type  <= w_ct_nxt;
            r_change_val   <= w_cval_nxt;
        end
    end

    assign current_amount = r_amount;
    assign coin_accept    = r_coin_accept;
    assign coin_reject    = r_coin_reject;
    assign change_valid   = r_change_valid;
    assign change_type    = r_change_type;
    assign busy           = (r_state == ST_REFUND);

endmodule

// File: tb/tb_coin_accumulator.sv
// Bench for coin_accumulator: directed scenarios plus random traffic, checked
// against a credit/change-list model of the accumulator's behaviour.
module tb_coin_accumulator;

    localparam int AMT_W      = 5;
    localparam int MAX_AMOUNT = 31;
    localparam int CHANGE_GAP = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             coin_valid;
    logic [1:0]       coin_type;
    logic             cancel;
    logic             vend;
    logic [AMT_W-1:0] product_price;
    logic [AMT_W-1:0] current_amount;
    logic             coin_accept;
    logic             coin_reject;
    logic             change_valid;
    logic [1:0]       change_type;
    logic             busy;

    coin_accumulator #(
        .AMT_W(AMT_W), .MAX_AMOUNT(MAX_AMOUNT), .CHANGE_GAP(CHANGE_GAP)
    ) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
        .cancel(cancel), .vend(vend), .product_price(product_price),
        .current_amount(current_amount), .coin_accept(coin_accept),
        .coin_reject(coin_reject), .change_valid(change_valid),
        .change_type(change_type), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: credit while collecting; while refunding, the full list of change
    // coins fixed at refund entry and the cycle index since entry.
    bit m_ref;
    int m_credit;
    int m_total;
    int m_k;
    int m_len;
    int m_chg[$];
    int m_accept;
    int m_reject;

    function automatic int val_of(input logic [1:0] t);
        case (t)
            2'b00: return 1;
            2'b01: return 2;
            2'b10: return 5;
            default: return 10;
        endcase
    endfunction

    function automatic logic [1:0] type_of(input int v);
        if (v == 10) return 2'b11;
        if (v == 5)  return 2'b10;
        if (v == 2)  return 2'b01;
        return 2'b00;
    endfunction

    task automatic m_start_refund(input int t);
        int r;
        r = t;
        m_ref = 1'b1;
        m_total = t;
        m_k = 0;
        m_chg.delete();
        while (r > 0) begin
            if (r >= 10)     begin m_chg.push_back(10); r -= 10; end
            else if (r >= 5) begin m_chg.push_back(5);  r -= 5;  end
            else if (r >= 2) begin m_chg.push_back(2);  r -= 2;  end
            else             begin m_chg.push_back(1);  r -= 1;  end
        end
        m_len = (m_chg.size() - 1) * CHANGE_GAP + 2;
    endtask

    task automatic m_reset();
        m_ref = 1'b0;
        m_credit = 0;
        m_accept = 0;
        m_reject = 0;
        m_chg.delete();
    endtask

    task automatic m_step();
        bit taken;
        m_accept = 0;
        m_reject = 0;
        if (m_ref) begin
            m_reject = int'(coin_valid);
            m_k++;
            if (m_k >= m_len) begin
                m_ref = 1'b0;
                m_credit = 0;
            end
        end else begin
            taken = 1'b0;
            if (vend && m_credit >= int'(product_price)) begin
                taken = 1'b1;
                if (m_credit == int'(product_price)) m_credit = 0;
                else m_start_refund(m_credit - int'(product_price));
            end else if (cancel && m_credit != 0) begin
                taken = 1'b1;
                m_start_refund(m_credit);
            end
            if (coin_valid) begin
                if (!taken && m_credit + val_of(coin_type) <= MAX_AMOUNT) begin
                    m_accept = 1;
                    m_credit += val_of(coin_type);
                end else begin
                    m_reject = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        int amt;
        bit pulse;
        pulse = m_ref && (m_k % CHANGE_GAP == 0) && (m_k / CHANGE_GAP < m_chg.size());
        if (m_ref) begin
            amt = m_total;
            foreach (m_chg[j]) if (j * CHANGE_GAP + 1 <= m_k) amt -= m_chg[j];
        end else begin
            amt = m_credit;
        end
        check_val("amount", 32'(current_amount), 32'(amt));
        check_val("coin_accept", 32'(coin_accept), 32'(m_accept));
        check_val("coin_reject", 32'(coin_reject), 32'(m_reject));
        check_val("change_valid", 32'(change_valid), 32'(pulse));
        check_val("busy", 32'(busy), 32'(m_ref));
        if (pulse) check_val("change_type", 32'(change_type), 32'(type_of(m_chg[m_k / CHANGE_GAP])));
    endtask

    task automatic cyc(input logic cv, input logic [1:0] ct, input logic cn,
                       input logic vd, input logic [AMT_W-1:0] pr);
        coin_valid = cv;
        coin_type = ct;
        cancel = cn;
        vend = vd;
        product_price = pr;
        m_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0, '0);
    endtask

    task automatic coin(input logic [1:0] ct);
        cyc(1'b1, ct, 1'b0, 1'b0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && busy; i++) idle(1);
        check_val("drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_amount"}, 32'(current_amount), 32'd0);
        check_val({tag, "_accept"}, 32'(coin_accept), 32'd0);
        check_val({tag, "_reject"}, 32'(coin_reject), 32'd0);
        check_val({tag, "_cv"}, 32'(change_valid), 32'd0);
        check_val({tag, "_ct"}, 32'(change_type), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Entered #1 after a rising edge; asserts reset between edges.
    task automatic mid_reset();
        coin_valid = 1'b0;
        cancel = 1'b0;
        vend = 1'b0;
        #3 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        m_reset();
        @(posedge clk);
        #1 check_reset_outputs("held_rst");
        #2 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        coin_valid = 1'b0;
        coin_type = 2'b00;
        cancel = 1'b0;
        vend = 1'b0;
        product_price = '0;
        m_reset();
        #12 check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // coins 5,2,1
        coin(2'b10); coin(2'b01); coin(2'b00);
        check_val("t1_amount", 32'(current_amount), 32'd8);

        // ceiling: 25 + 10 rejected, +5 accepted
        coin(2'b11); coin(2'b10); coin(2'b01);
        coin(2'b11);
        check_val("t2_reject", 32'(coin_reject), 32'd1);
        coin(2'b10);
        check_val("t2_amount", 32'(current_amount), 32'd30);
        cyc(1'b0, 2'b00, 1'b1, 1'b0, '0);
        drain();

        // cancel refund of 18 with a coin inserted mid-refund
        coin(2'b11); coin(2'b10); coin(2'b01); coin(2'b00);
        cyc(1'b0, 2'b00, 1'b1, 1'b0, '0);
        idle(2);
        coin(2'b10);
        drain();

        // vend: remainder 3, exact price, too-high price
        coin(2'b11); coin(2'b10);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 5'd12);
        drain();
        coin(2'b11); coin(2'b10);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 5'd15);
        check_val("t4_exact_busy", 32'(busy), 32'd0);
        coin(2'b11); coin(2'b10);
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 5'd20);
        check_val("t4_ignored_amt", 32'(current_amount), 32'd15);
        cyc(1'b0, 2'b00, 1'b1, 1'b0, '0);
        drain();

        // vend + cancel + coin together
        coin(2'b11);
        cyc(1'b1, 2'b00, 1'b1, 1'b1, 5'd10);
        check_val("t5_reject", 32'(coin_reject), 32'd1);
        idle(3);

        // reset in the middle of a refund of 13
        coin(2'b11); coin(2'b01); coin(2'b00);
        cyc(1'b0, 2'b00, 1'b1, 1'b0, '0);
        idle(2);
        mid_reset();
        coin(2'b00);
        check_val("t6_amount", 32'(current_amount), 32'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                mid_reset();
            end else begin
                cyc($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                    AMT_W'($urandom_range(0, 31)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
